// File: rtl/arbiter_puf_pkg.sv
// Shared definitions for the arbiter-PUF controller.
//   state_e     : controller FSM states
//   lfsr_taps   : Fibonacci LFSR feedback mask for a given register length
//   vote_cnt_w  : width needed to count 0..n_vote
package arbiter_puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_REARM  = 3'd5,
        ST_VOTE   = 3'd6,
        ST_DONE   = 3'd7
    } state_e;

    // Feedback mask for a right-shifting Fibonacci LFSR (new bit enters the MSB).
    // Polynomial tap x^k maps to state bit (len - k); x^len is always bit 0.
    // Example len=8: x^8+x^6+x^5+x^4+1 -> bits {0,2,3,4} = 8'h1D.
    function automatic logic [31:0] lfsr_taps(input int unsigned len);
        logic [31:0] m;
        case (len)
            32'd4:   m = 32'h0000_0003;
            32'd5:   m = 32'h0000_0005;
            32'd6:   m = 32'h0000_0003;
            32'd7:   m = 32'h0000_0003;
            32'd8:   m = 32'h0000_001D;
            32'd9:   m = 32'h0000_0011;
            32'd10:  m = 32'h0000_0009;
            32'd11:  m = 32'h0000_0005;
            32'd12:  m = 32'h0000_0941;
            32'd13:  m = 32'h0000_1601;
            32'd14:  m = 32'h0000_2A01;
            32'd15:  m = 32'h0000_0003;
            32'd16:  m = 32'h0000_100B;
            32'd17:  m = 32'h0000_0009;
            32'd18:  m = 32'h0000_0081;
            32'd19:  m = 32'h0006_2001;
            32'd20:  m = 32'h0000_0009;
            32'd21:  m = 32'h0000_0005;
            32'd22:  m = 32'h0000_0003;
            32'd23:  m = 32'h0000_0021;
            32'd24:  m = 32'h0000_0087;
            32'd25:  m = 32'h0000_0009;
            32'd26:  m = 32'h0310_0001;
            32'd27:  m = 32'h0640_0001;
            32'd28:  m = 32'h0000_0009;
            32'd29:  m = 32'h0000_0005;
            32'd30:  m = 32'h2500_0001;
            32'd31:  m = 32'h0000_0009;
            32'd32:  m = 32'hC000_0401;
            default: m = 32'h0000_0003;
        endcase
        return m;
    endfunction

    function automatic int unsigned vote_cnt_w(input int unsigned n_vote);
        return $clog2(n_vote + 32'd1);
    endfunction

endpackage

// File: rtl/arbiter_puf_ctrl_race_chain.sv
// Mux race chain with arbiter flop and 2-flop synchroniser.
//   clk        : system clock (synchroniser domain)
//   rst_n      : asynchronous active-low reset
//   pulse_i    : launch pulse, driven into both rails
//   chal_i     : per-stage swap control (1 = cross the rails)
//   arb_sync_o : arbiter decision synchronised into clk
module race_chain #(
    parameter int unsigned C_LENGTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pulse_i,
    input  logic [C_LENGTH-1:0] chal_i,
    output logic                arb_sync_o
);

    (* keep = "true", dont_touch = "true" *) logic rail_a_s;
    (* keep = "true", dont_touch = "true" *) logic rail_b_s;
    (* keep = "true", dont_touch = "true" *) logic arb_q;
    (* keep = "true", dont_touch = "true" *) logic [1:0] sync_q;

    // Mux stages: each stage either passes the rails straight or crosses them.
    always_comb begin
        logic a_v;
        logic b_v;
        logic na_v;
        logic nb_v;
        a_v = pulse_i;
        b_v = pulse_i;
        for (int i = 0; i < int'(C_LENGTH); i++) begin
            na_v = chal_i[i] ? b_v : a_v;
            nb_v = chal_i[i] ? a_v : b_v;
            a_v  = na_v;
            b_v  = nb_v;
        end
        rail_a_s = a_v;
        rail_b_s = b_v;
    end

    // Arbiter: rail A edge captures whether rail B already arrived.
    always_ff @(posedge rail_a_s or negedge rst_n) begin
        if (!rst_n) begin
            arb_q <= 1'b0;
        end else begin
            arb_q <= rail_b_s;
        end
    end

    // Two-flop synchroniser into the system clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], arb_q};
        end
    end

    assign arb_sync_o = sync_q[1];

endmodule

// File: rtl/arbiter_puf_ctrl.sv
// Arbiter-PUF query engine: one start produces N_RESP majority-voted bits,
// each from N_VOTE races on an LFSR-derived challenge, plus an instability mask.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start_i               : query request (accepted in IDLE only)
//   challenge_i           : LFSR seed (0 replaced by all-ones)
//   tm_en_i, tm_bit_i     : test mode, force race result
//   busy_o, done_o        : query in progress / one-cycle completion pulse
//   response_o, unstable_o: voted response and non-unanimous-vote mask
//   cur_chal_o            : challenge currently applied to the chain
module arbiter_puf_ctrl
    import arbiter_puf_pkg::*;
#(
    parameter int unsigned C_LENGTH   = 8,
    parameter int unsigned N_RESP     = 8,
    parameter int unsigned N_VOTE     = 5,
    parameter int unsigned SETTLE_CYC = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [C_LENGTH-1:0] challenge_i,
    input  logic                tm_en_i,
    input  logic                tm_bit_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [N_RESP-1:0]   response_o,
    output logic [N_RESP-1:0]   unstable_o,
    output logic [C_LENGTH-1:0] cur_chal_o
);

    localparam int unsigned VCW = vote_cnt_w(N_VOTE);
    localparam int unsigned SCW = $clog2(SETTLE_CYC);
    localparam int unsigned BW  = (N_RESP > 32'd1) ? $clog2(N_RESP) : 32'd1;
    localparam logic [C_LENGTH-1:0] TAP_MASK = C_LENGTH'(lfsr_taps(C_LENGTH));

    if ((N_VOTE % 32'd2) == 32'd0) begin : g_bad_vote
        $error("arbiter_puf_ctrl: N_VOTE must be odd");
    end
    if (SETTLE_CYC < 32'd3) begin : g_bad_settle
        $error("arbiter_puf_ctrl: SETTLE_CYC must be at least 3");
    end

    state_e              state_q, state_d;
    logic [SCW-1:0]      cnt_q, cnt_d;
    logic [VCW-1:0]      vote_q, vote_d;
    logic [VCW-1:0]      ones_q, ones_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [C_LENGTH-1:0] chal_q, chal_d;
    logic [N_RESP-1:0]   resp_q, resp_d;
    logic [N_RESP-1:0]   unst_q, unst_d;
    logic                pulse_q, pulse_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                arb_sync_s;
    logic                race_bit_s;

    race_chain #(.C_LENGTH(C_LENGTH)) u_chain (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_i   (pulse_q),
        .chal_i    (chal_q),
        .arb_sync_o(arb_sync_s)
    );

    // Test mode overrides the synchronised race result.
    assign race_bit_s = tm_en_i ? tm_bit_i : arb_sync_s;

    // Next-state and datapath logic of the query FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vote_d  = vote_q;
        ones_d  = ones_q;
        bit_d   = bit_q;
        chal_d  = chal_q;
        resp_d  = resp_q;
        unst_d  = unst_q;
        pulse_d = pulse_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Zero would lock the LFSR, so it is replaced by all-ones.
                if (challenge_i == {C_LENGTH{1'b0}}) begin
                    chal_d = {C_LENGTH{1'b1}};
                end else begin
                    chal_d = challenge_i;
                end
                bit_d   = {BW{1'b0}};
                vote_d  = {VCW{1'b0}};
                ones_d  = {VCW{1'b0}};
                cnt_d   = {SCW{1'b0}};
                resp_d  = {N_RESP{1'b0}};
                unst_d  = {N_RESP{1'b0}};
                state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                pulse_d = 1'b1;
                cnt_d   = {SCW{1'b0}};
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == SCW'(SETTLE_CYC - 32'd1)) begin
                    cnt_d   = {SCW{1'b0}};
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + SCW'(1);
                end
            end
            ST_SAMPLE: begin
                ones_d  = ones_q + {{(VCW-1){1'b0}}, race_bit_s};
                state_d = ST_REARM;
            end
            ST_REARM: begin
                pulse_d = 1'b0;
                if (cnt_q == SCW'(SETTLE_CYC - 32'd1)) begin
                    cnt_d = {SCW{1'b0}};
                    if (vote_q == VCW'(N_VOTE - 32'd1)) begin
                        vote_d  = {VCW{1'b0}};
                        state_d = ST_VOTE;
                    end else begin
                        vote_d  = vote_q + VCW'(1);
                        state_d = ST_LAUNCH;
                    end
                end else begin
                    cnt_d = cnt_q + SCW'(1);
                end
            end
            ST_VOTE: begin
                resp_d[bit_q] = (ones_q > VCW'(N_VOTE / 32'd2));
                unst_d[bit_q] = (ones_q != {VCW{1'b0}}) && (ones_q != VCW'(N_VOTE));
                chal_d        = {^(chal_q & TAP_MASK), chal_q[C_LENGTH-1:1]};
                ones_d        = {VCW{1'b0}};
                if (bit_q == BW'(N_RESP - 32'd1)) begin
                    state_d = ST_DONE;
                end else begin
                    bit_d   = bit_q + BW'(1);
                    state_d = ST_LAUNCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status outputs are registered from the upcoming state so done
        // coincides with DONE and busy drops in the same cycle.
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset aborts a query immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {SCW{1'b0}};
            vote_q  <= {VCW{1'b0}};
            ones_q  <= {VCW{1'b0}};
            bit_q   <= {BW{1'b0}};
            chal_q  <= {C_LENGTH{1'b0}};
            resp_q  <= {N_RESP{1'b0}};
            unst_q  <= {N_RESP{1'b0}};
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vote_q  <= vote_d;
            ones_q  <= ones_d;
            bit_q   <= bit_d;
            chal_q  <= chal_d;
            resp_q  <= resp_d;
            unst_q  <= unst_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign response_o = resp_q;
    assign unstable_o = unst_q;
    assign cur_chal_o = chal_q;

endmodule
